// File: rtl/ccp_responder_pkg.sv
// Shared definitions for the CCP grant responder: FSM state encoding,
// source codes and a saturating counter helper.
package ccp_responder_pkg;

  typedef enum logic {
    CCP_ST_RUN     = 1'b0,
    CCP_ST_BACKOFF = 1'b1
  } ccpState_e;

  localparam logic CCP_SRC_A = 1'b0;
  localparam logic CCP_SRC_B = 1'b1;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'h01;
    end
  endfunction

endpackage

// File: rtl/ccp_fifo.sv
// Small synchronous FIFO holding {src, data} words for the CCP responder.
// Pointers wrap naturally; count is one bit wider than the pointers.
module ccp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [CW-1:0]    count_r;
  logic             pushEn_s;
  logic             popEn_s;

  assign full     = (count_r == CW'(DEPTH));
  assign empty    = (count_r == {CW{1'b0}});
  assign pushEn_s = push & ~full;
  assign popEn_s  = pop & ~empty;
  assign rdData   = mem_r[rdPtr_r];

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (pushEn_s) begin
      mem_r[wrPtr_r] <= wrData;
    end
  end

  // Write and read pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
    end else begin
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + AW'(1'b1);
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + AW'(1'b1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({pushEn_s, popEn_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ccp_responder.sv
// Receiving end of the CCP grant protocol: captures the granted writer's word
// into a FIFO, throttles via readySignal and backs off after collisions.
// Optional error counter enabled by defining CCP_ERRCNT_EN.
module ccp_responder
  import ccp_responder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int BACKOFF_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signalA,
  input  logic              signalB,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic              readySignal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              err_pulse
`ifdef CCP_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [BW-1:0] BoLoad = BW'(BACKOFF_CYC - 1);

  ccpState_e       state_r;
  ccpState_e       stateNext_s;
  logic [BW-1:0]   boCnt_r;
  logic [BW-1:0]   boCntNext_s;
  logic            fifoFull_s;
  logic            fifoEmpty_s;
  logic            grantOne_s;
  logic            collision_s;
  logic            push_s;
  logic            pop_s;
  logic            dropped_s;
  logic            errEvent_s;
  logic [DATA_W:0] wrWord_s;
  logic [DATA_W:0] rdWord_s;
  logic            errPulse_r;

  assign grantOne_s  = signalA ^ signalB;
  assign collision_s = signalA & signalB;

  // Held low during reset so the controller never sees a spurious ready.
  assign readySignal = rst_n & (state_r == CCP_ST_RUN) & ~fifoFull_s;

  assign push_s     = grantOne_s & readySignal;
  assign pop_s      = out_valid & out_ready;
  assign dropped_s  = (state_r == CCP_ST_RUN) & grantOne_s & ~readySignal;
  assign errEvent_s = collision_s | dropped_s;

  assign wrWord_s  = signalB ? {CCP_SRC_B, dataB} : {CCP_SRC_A, dataA};
  assign out_valid = ~fifoEmpty_s;
  assign out_data  = rdWord_s[DATA_W-1:0];
  assign out_src   = rdWord_s[DATA_W];
  assign err_pulse = errPulse_r;

  ccp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .pop    (pop_s),
    .wrData (wrWord_s),
    .rdData (rdWord_s),
    .full   (fifoFull_s),
    .empty  (fifoEmpty_s)
  );

  // FSM and backoff counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CCP_ST_RUN;
      boCnt_r <= {BW{1'b0}};
    end else begin
      state_r <= stateNext_s;
      boCnt_r <= boCntNext_s;
    end
  end

  // Next-state logic: a collision (re)arms the backoff window from either state.
  always_comb begin
    stateNext_s = state_r;
    boCntNext_s = boCnt_r;
    case (state_r)
      CCP_ST_RUN: begin
        if (collision_s) begin
          stateNext_s = CCP_ST_BACKOFF;
          boCntNext_s = BoLoad;
        end else begin
          stateNext_s = CCP_ST_RUN;
        end
      end
      CCP_ST_BACKOFF: begin
        if (collision_s) begin
          boCntNext_s = BoLoad;
        end else if (boCnt_r == {BW{1'b0}}) begin
          stateNext_s = CCP_ST_RUN;
        end else begin
          boCntNext_s = boCnt_r - BW'(1'b1);
        end
      end
      default: begin
        stateNext_s = CCP_ST_RUN;
        boCntNext_s = {BW{1'b0}};
      end
    endcase
  end

  // One-cycle error pulse for collisions and dropped grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errPulse_r <= 1'b0;
    end else begin
      errPulse_r <= errEvent_s;
    end
  end

`ifdef CCP_ERRCNT_EN
  logic [7:0] errCount_r;

  // Saturating error event counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount_r <= 8'h00;
    end else if (errEvent_s) begin
      errCount_r <= satInc8(errCount_r);
    end
  end

  assign err_count = errCount_r;
`endif

endmodule

// File: tb/tb_ccp_responder.sv
// Self-checking bench for ccp_responder: directed scenarios plus randomized
// grants checked against a queue-based reference model.
module tb_ccp_responder;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int BACKOFF_CYC = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              signalA;
  logic              signalB;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic              readySignal;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              err_pulse;
`ifdef CCP_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of {src,data}, remaining blocked cycles, error state.
  logic [DATA_W:0] mq[$];
  int              blocked;
  logic            errPend;
  int              errCnt;

  ccp_responder #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .BACKOFF_CYC (BACKOFF_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signalA     (signalA),
    .signalB     (signalB),
    .dataA       (dataA),
    .dataB       (dataB),
    .readySignal (readySignal),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .err_pulse   (err_pulse)
`ifdef CCP_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic mReady();
    return (blocked == 0) && (mq.size() < DEPTH);
  endfunction

  function automatic logic [DATA_W:0] mHead();
    if (mq.size() == 0) return {(DATA_W+1){1'b0}};
    return mq[0];
  endfunction

  // Advance the model by the current inputs, then one clock edge.
  task automatic tick();
    logic single, coll, rdy, push, pop, drop;
    logic [DATA_W:0] tmp;
    single = signalA ^ signalB;
    coll   = signalA & signalB;
    rdy    = mReady();
    push   = single && rdy;
    pop    = (mq.size() != 0) && out_ready;
    drop   = (blocked == 0) && single && !rdy;
    if (pop) tmp = mq.pop_front();
    if (push) mq.push_back({signalB, signalB ? dataB : dataA});
    errPend = coll || drop;
    if (errPend && errCnt < 255) errCnt++;
    if (coll) blocked = BACKOFF_CYC;
    else if (blocked > 0) blocked--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    signalA = 1'b0; signalB = 1'b0; out_ready = 1'b0;
    dataA = 8'h00; dataB = 8'h00;
  endtask

  task automatic model_reset();
    mq.delete();
    blocked = 0; errPend = 1'b0; errCnt = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      signalA = 1'b1; dataA = 8'($urandom_range(0, 118)); // never 8'h77
      tick();
    end
    signalA = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mq.size() != 0) tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    signalA = 1'b1; dataA = 8'hEE;
    @(posedge clk); #1;
    vectors++; if (readySignal !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", readySignal); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", out_data); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset_src got=%b want=0", out_src); end
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", err_pulse); end
`ifdef CCP_ERRCNT_EN
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL reset_errcnt got=%h want=00", err_count); end
`endif
    signalA = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (readySignal !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got=%b want=1", readySignal); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_single();
    signalA = 1'b1; dataA = 8'h5A;
    tick();
    signalA = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%b want=1", out_valid); end
    vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL single_data got=%h want=5a", out_data); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL single_src got=%b want=0", out_src); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop got=%b want=0", out_valid); end
  endtask

  task automatic test_order();
    logic [7:0] words [4];
    logic       srcs  [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    srcs[0] = 1'b0; srcs[1] = 1'b1; srcs[2] = 1'b0; srcs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      signalA = ~srcs[i]; signalB = srcs[i];
      dataA = words[i]; dataB = words[i];
      tick();
    end
    signalA = 1'b0; signalB = 1'b0;
    vectors++; if (readySignal !== 1'b0) begin miscompares++; $display("FAIL order_full_ready got=%b want=0", readySignal); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== words[i] || out_src !== srcs[i]) begin
        miscompares++;
        $display("FAIL order_pop%0d got=%b/%h/%b want=1/%h/%b", i, out_valid, out_data, out_src, words[i], srcs[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_drop();
    fill(DEPTH);
    signalB = 1'b1; dataB = 8'h77;
    tick();
    signalB = 1'b0;
    vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL drop_err got=%b want=1", err_pulse); end
    tick();
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL drop_err_len got=%b want=0", err_pulse); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (out_data === 8'h77 || {out_src, out_data} !== mHead()) begin
        miscompares++;
        $display("FAIL drop_drain%0d got=%b/%h want=%h", i, out_src, out_data, mHead());
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_collision();
    signalA = 1'b1; signalB = 1'b1; dataA = 8'hA1; dataB = 8'hB2;
    tick();
    signalA = 1'b0; signalB = 1'b0;
    vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL coll_err got=%b want=1", err_pulse); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL coll_nopush got=%b want=0", out_valid); end
    vectors++; if (readySignal !== 1'b0) begin miscompares++; $display("FAIL coll_ready1 got=%b want=0", readySignal); end
    tick();
    vectors++; if (readySignal !== 1'b0) begin miscompares++; $display("FAIL coll_ready2 got=%b want=0", readySignal); end
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL coll_err_len got=%b want=0", err_pulse); end
    tick();
    vectors++; if (readySignal !== 1'b1) begin miscompares++; $display("FAIL coll_ready3 got=%b want=1", readySignal); end
  endtask

  task automatic test_full_pushpop();
    logic [DATA_W:0] second;
    fill(DEPTH);
    second = mq[1];
    out_ready = 1'b1; signalA = 1'b1; dataA = 8'hC3;
    tick();
    out_ready = 1'b0; signalA = 1'b0;
    vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL fpp_err got=%b want=1", err_pulse); end
    vectors++; if (readySignal !== 1'b1) begin miscompares++; $display("FAIL fpp_ready got=%b want=1", readySignal); end
    vectors++; if ({out_src, out_data} !== second) begin miscompares++; $display("FAIL fpp_head got=%h want=%h", {out_src, out_data}, second); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fpp_count got_valid=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 11);
      signalA = (r <= 1) || (r >= 2 && r <= 5);
      signalB = (r <= 1) || (r >= 6 && r <= 9);
      dataA = 8'($urandom); dataB = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      vectors++;
      if (readySignal !== mReady() || out_valid !== (mq.size() != 0) || err_pulse !== errPend ||
          (mq.size() != 0 && {out_src, out_data} !== mHead())) begin
        miscompares++;
        $display("FAIL rand%0d got rdy=%b v=%b e=%b w=%h want rdy=%b v=%b e=%b w=%h", n,
                 readySignal, out_valid, err_pulse, {out_src, out_data},
                 mReady(), (mq.size() != 0), errPend, mHead());
      end
`ifdef CCP_ERRCNT_EN
      vectors++; if (err_count !== 8'(errCnt)) begin miscompares++; $display("FAIL rand_errcnt%0d got=%0d want=%0d", n, err_count, errCnt); end
`endif
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    test_reset();
    fill(3);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ares_pre got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ares_valid got=%b want=0", out_valid); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (readySignal !== 1'b1) begin miscompares++; $display("FAIL ares_ready got=%b want=1", readySignal); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ares_empty got=%b want=0", out_valid); end
`ifdef CCP_ERRCNT_EN
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL ares_errcnt got=%h want=00", err_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_drop();
    test_collision();
    test_full_pushpop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
